// File: rtl/vga_scan_gen_if.sv
// Raster timing bundle driven by vga_scan_gen toward the bitmap pixel stage.
// The *_d members are the same sync/enable strobes delayed to match screen-memory read latency.
interface vga_scan_gen_if;
  logic [9:0] posx;
  logic [8:0] posy;
  logic       active;
  logic       hsync;
  logic       vsync;
  logic       line_start;
  logic       frame_start;
  logic       active_d;
  logic       hsync_d;
  logic       vsync_d;

  modport master (
    output posx, posy, active, hsync, vsync, line_start, frame_start,
           active_d, hsync_d, vsync_d
  );

  modport slave (
    input  posx, posy, active, hsync, vsync, line_start, frame_start,
           active_d, hsync_d, vsync_d
  );
endinterface

// File: rtl/vga_scan_gen.sv
// Raster scan timing generator: horizontal/vertical counters, registered coordinate and
// sync decode, plus a PIPE_DLY-deep delayed copy of active/hsync/vsync.
module vga_scan_gen #(
  parameter int   H_ACTIVE = 640,
  parameter int   H_FP     = 16,
  parameter int   H_SYNC   = 96,
  parameter int   H_BP     = 48,
  parameter int   V_ACTIVE = 480,
  parameter int   V_FP     = 10,
  parameter int   V_SYNC   = 2,
  parameter int   V_BP     = 33,
  parameter logic HS_POL   = 1'b0,
  parameter logic VS_POL   = 1'b0,
  parameter int   PIPE_DLY = 1
) (
  input  logic           clk,
  input  logic           rst_n,
  vga_scan_gen_if.master vga_o
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [10:0] H_LAST = 11'(H_TOTAL - 1);
  localparam logic [10:0] V_LAST = 11'(V_TOTAL - 1);
  localparam logic [10:0] H_ACT  = 11'(H_ACTIVE);
  localparam logic [10:0] V_ACT  = 11'(V_ACTIVE);
  localparam logic [10:0] HS_BEG = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] HS_END = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [10:0] VS_BEG = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0] VS_END = 11'(V_ACTIVE + V_FP + V_SYNC);

  logic [10:0] hcnt_q, hcnt_d;
  logic [10:0] vcnt_q, vcnt_d;
  logic [9:0]  posx_q, posx_d;
  logic [8:0]  posy_q, posy_d;
  logic        act_q, act_d;
  logic        hs_q, hs_d;
  logic        vs_q, vs_d;
  logic        ls_q, ls_d;
  logic        fs_q, fs_d;
  logic        hwrap;

  // Outputs decode the counter value of this cycle, so they trail the counters by one clock.
  always_comb begin
    hwrap  = (hcnt_q == H_LAST);
    hcnt_d = hwrap ? '0 : hcnt_q + 11'd1;
    vcnt_d = vcnt_q;
    if (hwrap) begin
      vcnt_d = (vcnt_q == V_LAST) ? '0 : vcnt_q + 11'd1;
    end

    act_d  = (hcnt_q < H_ACT) && (vcnt_q < V_ACT);
    hs_d   = ((hcnt_q >= HS_BEG) && (hcnt_q < HS_END)) ? HS_POL : ~HS_POL;
    vs_d   = ((vcnt_q >= VS_BEG) && (vcnt_q < VS_END)) ? VS_POL : ~VS_POL;
    posx_d = act_d ? hcnt_q[9:0] : '0;
    posy_d = act_d ? vcnt_q[8:0] : '0;
    ls_d   = (hcnt_q == '0);
    fs_d   = ls_d && (vcnt_q == '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hcnt_q <= '0;
      vcnt_q <= '0;
      posx_q <= '0;
      posy_q <= '0;
      act_q  <= 1'b0;
      hs_q   <= ~HS_POL;
      vs_q   <= ~VS_POL;
      ls_q   <= 1'b0;
      fs_q   <= 1'b0;
    end else begin
      hcnt_q <= hcnt_d;
      vcnt_q <= vcnt_d;
      posx_q <= posx_d;
      posy_q <= posy_d;
      act_q  <= act_d;
      hs_q   <= hs_d;
      vs_q   <= vs_d;
      ls_q   <= ls_d;
      fs_q   <= fs_d;
    end
  end

  assign vga_o.posx        = posx_q;
  assign vga_o.posy        = posy_q;
  assign vga_o.active      = act_q;
  assign vga_o.hsync       = hs_q;
  assign vga_o.vsync       = vs_q;
  assign vga_o.line_start  = ls_q;
  assign vga_o.frame_start = fs_q;

  // Delay taps hold {active, hsync, vsync}; reset flushes them to the inactive levels.
  if (PIPE_DLY == 0) begin : g_nodly
    assign vga_o.active_d = act_q;
    assign vga_o.hsync_d  = hs_q;
    assign vga_o.vsync_d  = vs_q;
  end else begin : g_dly
    logic [2:0] dly_q [PIPE_DLY];

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int i = 0; i < PIPE_DLY; i++) begin
          dly_q[i] <= {1'b0, ~HS_POL, ~VS_POL};
        end
      end else begin
        dly_q[0] <= {act_q, hs_q, vs_q};
        for (int i = 1; i < PIPE_DLY; i++) begin
          dly_q[i] <= dly_q[i-1];
        end
      end
    end

    assign {vga_o.active_d, vga_o.hsync_d, vga_o.vsync_d} = dly_q[PIPE_DLY-1];
  end

endmodule

// File: tb/tb_vga_scan_gen.sv
// Self-checking bench for vga_scan_gen: a default-timing instance plus two shrunken rasters
// (delay 2, and inverted sync polarity with delay 0) checked against an arithmetic raster model.
module tb_vga_scan_gen;

  typedef struct packed {
    logic [9:0] posx;
    logic [8:0] posy;
    logic       active;
    logic       hsync;
    logic       vsync;
    logic       line_start;
    logic       frame_start;
    logic       active_d;
    logic       hsync_d;
    logic       vsync_d;
  } out_t;

  typedef struct {
    int ha, hfp, hs, hbp, va, vfp, vs, vbp;
    bit hp, vp;
    int dly;
  } cfg_t;

  logic clk;
  logic rst_n;
  int   k;
  int   tests;
  int   fails;
  cfg_t cfg [3];
  out_t obs [3];

  vga_scan_gen_if ifA ();
  vga_scan_gen_if ifB ();
  vga_scan_gen_if ifC ();

  vga_scan_gen dutA (.clk(clk), .rst_n(rst_n), .vga_o(ifA));

  vga_scan_gen #(
    .H_ACTIVE(20), .H_FP(3), .H_SYNC(5), .H_BP(4),
    .V_ACTIVE(12), .V_FP(2), .V_SYNC(3), .V_BP(2),
    .HS_POL(1'b0), .VS_POL(1'b0), .PIPE_DLY(2)
  ) dutB (.clk(clk), .rst_n(rst_n), .vga_o(ifB));

  vga_scan_gen #(
    .H_ACTIVE(20), .H_FP(3), .H_SYNC(5), .H_BP(4),
    .V_ACTIVE(12), .V_FP(2), .V_SYNC(3), .V_BP(2),
    .HS_POL(1'b1), .VS_POL(1'b1), .PIPE_DLY(0)
  ) dutC (.clk(clk), .rst_n(rst_n), .vga_o(ifC));

  assign obs[0] = {ifA.posx, ifA.posy, ifA.active, ifA.hsync, ifA.vsync, ifA.line_start,
                   ifA.frame_start, ifA.active_d, ifA.hsync_d, ifA.vsync_d};
  assign obs[1] = {ifB.posx, ifB.posy, ifB.active, ifB.hsync, ifB.vsync, ifB.line_start,
                   ifB.frame_start, ifB.active_d, ifB.hsync_d, ifB.vsync_d};
  assign obs[2] = {ifC.posx, ifC.posy, ifC.active, ifC.hsync, ifC.vsync, ifC.line_start,
                   ifC.frame_start, ifC.active_d, ifC.hsync_d, ifC.vsync_d};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Edges since reset release; the k-th edge shows raster position k-1.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) k <= 0;
    else        k <= k + 1;
  end

  function automatic out_t raw_model(cfg_t c, int kk);
    out_t o;
    int ht, vt, p, h, v;
    o = '0;
    o.hsync = ~c.hp;
    o.vsync = ~c.vp;
    if (kk < 1) return o;
    ht = c.ha + c.hfp + c.hs + c.hbp;
    vt = c.va + c.vfp + c.vs + c.vbp;
    p  = kk - 1;
    h  = p % ht;
    v  = (p / ht) % vt;
    o.active      = (h < c.ha) && (v < c.va);
    o.hsync       = (h >= c.ha + c.hfp && h < c.ha + c.hfp + c.hs) ? c.hp : ~c.hp;
    o.vsync       = (v >= c.va + c.vfp && v < c.va + c.vfp + c.vs) ? c.vp : ~c.vp;
    o.posx        = o.active ? 10'(h) : 10'd0;
    o.posy        = o.active ? 9'(v) : 9'd0;
    o.line_start  = (h == 0);
    o.frame_start = (h == 0) && (v == 0);
    return o;
  endfunction

  function automatic out_t model(cfg_t c, int kk);
    out_t o, past;
    o    = raw_model(c, kk);
    past = raw_model(c, kk - c.dly);
    o.active_d = past.active;
    o.hsync_d  = past.hsync;
    o.vsync_d  = past.vsync;
    return o;
  endfunction

  task automatic test_reset();
    out_t e;
    rst_n = 1'b0;
    repeat (5) @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      e = model(cfg[d], 0);
      tests++;
      if (obs[d] !== e) begin
        fails++;
        $display("[TB] FAIL reset_hold dut%0d got=%h exp=%h", d, obs[d], e);
      end
    end
    tests++;
    if ({ifC.hsync, ifC.vsync} !== 2'b00) begin
      fails++;
      $display("[TB] FAIL reset_pol_level got=%b exp=00", {ifC.hsync, ifC.vsync});
    end
    rst_n = 1'b1;
    @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      e = model(cfg[d], k);
      tests++;
      if (obs[d] !== e) begin
        fails++;
        $display("[TB] FAIL first_pixel dut%0d got=%h exp=%h", d, obs[d], e);
      end
    end
    tests++;
    if ({ifA.posx, ifA.posy, ifA.active, ifA.line_start, ifA.frame_start} !== {19'd0, 3'b111}) begin
      fails++;
      $display("[TB] FAIL first_pixel_flags got=%b exp=111", {ifA.active, ifA.line_start, ifA.frame_start});
    end
  endtask

  task automatic test_line_timing();
    out_t e;
    int   last_ls = -1;
    int   hs_low  = 0;
    for (int n = 0; n < 2400; n++) begin
      @(negedge clk);
      for (int d = 0; d < 3; d++) begin
        e = model(cfg[d], k);
        tests++;
        if (obs[d] !== e) begin
          fails++;
          $display("[TB] FAIL line_scan dut%0d k=%0d got=%h exp=%h", d, k, obs[d], e);
        end
      end
      if (ifA.line_start) begin
        if (last_ls >= 0) begin
          tests++;
          if (k - last_ls !== 800) begin
            fails++;
            $display("[TB] FAIL line_period got=%0d exp=800", k - last_ls);
          end
          tests++;
          if (hs_low !== 96) begin
            fails++;
            $display("[TB] FAIL hsync_width got=%0d exp=96", hs_low);
          end
        end
        last_ls = k;
        hs_low  = 0;
      end
      if (!ifA.hsync) hs_low++;
    end
  endtask

  task automatic test_frame_and_delay();
    out_t       e;
    logic [2:0] hist [$];
    int         last_fs = -1;
    for (int n = 0; n < 2 * 608 + 40; n++) begin
      @(negedge clk);
      for (int d = 0; d < 3; d++) begin
        e = model(cfg[d], k);
        tests++;
        if (obs[d] !== e) begin
          fails++;
          $display("[TB] FAIL frame_scan dut%0d k=%0d got=%h exp=%h", d, k, obs[d], e);
        end
      end
      hist.push_back({ifB.active, ifB.hsync, ifB.vsync});
      if (hist.size() >= 3) begin
        tests++;
        if ({ifB.active_d, ifB.hsync_d, ifB.vsync_d} !== hist[hist.size()-3]) begin
          fails++;
          $display("[TB] FAIL delay2 k=%0d got=%b exp=%b", k,
                   {ifB.active_d, ifB.hsync_d, ifB.vsync_d}, hist[hist.size()-3]);
        end
        void'(hist.pop_front());
      end
      if (ifB.frame_start) begin
        if (last_fs >= 0) begin
          tests++;
          if (k - last_fs !== 608) begin
            fails++;
            $display("[TB] FAIL frame_period got=%0d exp=608", k - last_fs);
          end
        end
        last_fs = k;
      end
    end
  endtask

  task automatic pulse_reset(string tag, int low_clocks, int offset);
    out_t e;
    #(offset) rst_n = 1'b0;
    #1;
    for (int d = 0; d < 3; d++) begin
      e = model(cfg[d], 0);
      tests++;
      if (obs[d] !== e) begin
        fails++;
        $display("[TB] FAIL %s_async dut%0d got=%h exp=%h", tag, d, obs[d], e);
      end
    end
    repeat (low_clocks) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      e = model(cfg[d], 1);
      tests++;
      if (obs[d] !== e) begin
        fails++;
        $display("[TB] FAIL %s_restart dut%0d got=%h exp=%h", tag, d, obs[d], e);
      end
    end
    tests++;
    if ({ifA.frame_start, ifB.frame_start, ifC.frame_start} !== 3'b111) begin
      fails++;
      $display("[TB] FAIL %s_frame_start got=%b exp=111", tag,
               {ifA.frame_start, ifB.frame_start, ifC.frame_start});
    end
  endtask

  task automatic test_mid_reset();
    bit found = 1'b0;
    for (int n = 0; n < 700 && !found; n++) begin
      @(negedge clk);
      if (k >= 1 && ((k - 1) % 608) == 7 * 32 + 13) found = 1'b1;
    end
    tests++;
    if (!found) begin
      fails++;
      $display("[TB] FAIL mid_reset_reach got=0 exp=1");
    end
    pulse_reset("mid_reset", 1, 1);
  endtask

  task automatic test_random_reset();
    out_t e;
    int   len;
    for (int it = 0; it < 4; it++) begin
      len = $urandom_range(20, 900);
      for (int n = 0; n < len; n++) begin
        @(negedge clk);
        for (int d = 0; d < 3; d++) begin
          e = model(cfg[d], k);
          tests++;
          if (obs[d] !== e) begin
            fails++;
            $display("[TB] FAIL rand_run dut%0d k=%0d got=%h exp=%h", d, k, obs[d], e);
          end
        end
      end
      pulse_reset("rand_reset", $urandom_range(1, 3), $urandom_range(1, 3));
    end
  endtask

  initial begin
    tests  = 0;
    fails  = 0;
    rst_n  = 1'b0;
    cfg[0] = '{640, 16, 96, 48, 480, 10, 2, 33, 1'b0, 1'b0, 1};
    cfg[1] = '{20, 3, 5, 4, 12, 2, 3, 2, 1'b0, 1'b0, 2};
    cfg[2] = '{20, 3, 5, 4, 12, 2, 3, 2, 1'b1, 1'b1, 0};
    test_reset();
    test_line_timing();
    test_frame_and_delay();
    test_mid_reset();
    test_random_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
